// File: rtl/duty_pkg.sv
// duty_pkg: shared widths, FSM state type and LFSR constants for duty_cycle_ctrl. Rev 1.0
`default_nettype none

package duty_pkg;
  localparam int DUTY_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OFF  = 2'd1,
    ON   = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

`default_nettype wire

// File: rtl/duty_phase_calc.sv
// duty_phase_calc: clamps a requested duty and derives ON/OFF cycle counts for the active duty. Rev 1.0
`default_nettype none

module duty_phase_calc
  import duty_pkg::*;
#(
  parameter int TP       = 10,
  parameter int DUTY_MIN = 10,
  parameter int DUTY_MAX = 80,
  parameter int CW       = $clog2(TP + 1)
) (
  input  logic [DUTY_W-1:0] req_duty,
  input  logic [DUTY_W-1:0] act_duty,
  output logic [DUTY_W-1:0] req_clamped,
  output logic              req_was_clamped,
  output logic [CW-1:0]     ton,
  output logic [CW-1:0]     toff
);

  localparam logic [DUTY_W-1:0] DMIN = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] DMAX = DUTY_W'(DUTY_MAX);

  always_comb begin
    req_clamped     = req_duty;
    req_was_clamped = 1'b0;
    if (req_duty < DMIN) begin
      req_clamped     = DMIN;
      req_was_clamped = 1'b1;
    end else if (req_duty > DMAX) begin
      req_clamped     = DMAX;
      req_was_clamped = 1'b1;
    end
  end

  // Product held at 32 bits so duty*TP never wraps before the divide
  assign ton  = CW'((32'(act_duty) * 32'(TP)) / 32'd100);
  assign toff = CW'(TP) - ton;

endmodule

`default_nettype wire

// File: rtl/duty_cycle_ctrl.sv
// duty_cycle_ctrl: period sequencer (OFF then ON) with valid/ready duty requests. Rev 1.0
// Optional DUTY_CYCLE_LFSR_EN adds rand_mode and an LFSR duty source.
`default_nettype none

module duty_cycle_ctrl
  import duty_pkg::*;
#(
  parameter int TP       = 10,
  parameter int DUTY_MIN = 10,
  parameter int DUTY_MAX = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              duty_valid,
  input  logic [DUTY_W-1:0] duty_in,
`ifdef DUTY_CYCLE_LFSR_EN
  input  logic              rand_mode,
`endif
  output logic              duty_ready,
  output logic              pwm,
  output logic              period_start,
  output logic [DUTY_W-1:0] cur_duty,
  output logic              duty_clamped
);

  localparam int                CW   = $clog2(TP + 1);
  localparam logic [DUTY_W-1:0] DMIN = DUTY_W'(DUTY_MIN);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              load, period_end, accept;
  logic              pend_full;
  logic [DUTY_W-1:0] pend_duty, load_duty, req_c;
  logic              req_clamp;
  logic [CW-1:0]     ton, toff;

  duty_phase_calc #(
    .TP       (TP),
    .DUTY_MIN (DUTY_MIN),
    .DUTY_MAX (DUTY_MAX),
    .CW       (CW)
  ) u_calc (
    .req_duty        (duty_in),
    .act_duty        (cur_duty),
    .req_clamped     (req_c),
    .req_was_clamped (req_clamp),
    .ton             (ton),
    .toff            (toff)
  );

  assign duty_ready = ~pend_full;
  assign accept     = duty_valid & ~pend_full;

`ifdef DUTY_CYCLE_LFSR_EN
  logic [15:0]       lfsr;
  logic [DUTY_W-1:0] lfsr_duty;
  assign lfsr_duty = DUTY_W'(DUTY_MIN + (int'(lfsr[7:0]) % (DUTY_MAX - DUTY_MIN + 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (load) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load       = 1'b0;
    period_end = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          load      = 1'b1;
          state_nxt = OFF;
          cnt_nxt   = CW'(1);
        end
      end
      OFF: begin
        if (cnt >= toff) begin
          if (ton != '0) begin
            state_nxt = ON;
            cnt_nxt   = CW'(1);
          end else begin
            period_end = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ON: begin
        if (cnt >= ton) period_end = 1'b1;
        else            cnt_nxt = cnt + CW'(1);
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (period_end) begin
      if (en) begin
        load      = 1'b1;
        state_nxt = OFF;
        cnt_nxt   = CW'(1);
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end
  end

  // Pending slot wins over a same-edge request; a request at a load with an empty slot bypasses it
  always_comb begin
    load_duty = cur_duty;
    if (pend_full)   load_duty = pend_duty;
    else if (accept) load_duty = req_c;
`ifdef DUTY_CYCLE_LFSR_EN
    if (rand_mode)   load_duty = lfsr_duty;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm          <= 1'b0;
      period_start <= 1'b0;
      duty_clamped <= 1'b0;
      cur_duty     <= DMIN;
      pend_full    <= 1'b0;
      pend_duty    <= DMIN;
    end else begin
      pwm          <= (state_nxt == ON);
      period_start <= load;
      duty_clamped <= accept & req_clamp;
      if (load) cur_duty <= load_duty;
      pend_full    <= load ? 1'b0 : (pend_full | accept);
      if (accept && !load) pend_duty <= req_c;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_duty_cycle_ctrl.sv
// tb_duty_cycle_ctrl: drives TP=10 and TP=5 instances against a period-position reference model. Rev 1.0
`default_nettype none

module tb_duty_cycle_ctrl;
  localparam int DMIN = 10;
  localparam int DMAX = 80;

  logic       clk = 1'b0;
  logic       rst, en, duty_valid;
  logic [6:0] duty_in;

  logic       ready10, pwm10, ps10, clmp10;
  logic [6:0] cur10;
  logic       ready5, pwm5, ps5, clmp5;
  logic [6:0] cur5;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  duty_cycle_ctrl #(.TP(10), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX)) u_dut10 (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_valid   (duty_valid),
    .duty_in      (duty_in),
`ifdef DUTY_CYCLE_LFSR_EN
    .rand_mode    (1'b0),
`endif
    .duty_ready   (ready10),
    .pwm          (pwm10),
    .period_start (ps10),
    .cur_duty     (cur10),
    .duty_clamped (clmp10)
  );

  duty_cycle_ctrl #(.TP(5), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX)) u_dut5 (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_valid   (duty_valid),
    .duty_in      (duty_in),
`ifdef DUTY_CYCLE_LFSR_EN
    .rand_mode    (1'b0),
`endif
    .duty_ready   (ready5),
    .pwm          (pwm5),
    .period_start (ps5),
    .cur_duty     (cur5),
    .duty_clamped (clmp5)
  );

  // Reference: position within the period plus the duty held for it
  typedef struct {
    bit running;
    int pos;
    int active;
    bit pfull;
    int pval;
    bit ps;
    bit clmp;
  } model_t;

  model_t m10, m5;

  function automatic int clampf(int d);
    if (d < DMIN) return DMIN;
    if (d > DMAX) return DMAX;
    return d;
  endfunction

  function automatic int exp_pwm(model_t m, int tp);
    return (m.running && m.pos >= tp - (m.active * tp) / 100) ? 1 : 0;
  endfunction

  task automatic model_reset(output model_t m);
    m.running = 0;
    m.pos     = 0;
    m.active  = DMIN;
    m.pfull   = 0;
    m.pval    = DMIN;
    m.ps      = 0;
    m.clmp    = 0;
  endtask

  task automatic model_step(inout model_t m, input int tp);
    bit acc, start;
    if (rst) begin
      model_reset(m);
      return;
    end
    acc    = duty_valid && !m.pfull;
    start  = en && (!m.running || m.pos == tp - 1);
    m.clmp = acc && (int'(duty_in) < DMIN || int'(duty_in) > DMAX);
    m.ps   = start;
    if (m.running && m.pos == tp - 1 && !en) m.running = 0;
    if (start) begin
      if (m.pfull) begin
        m.active = m.pval;
        m.pfull  = 0;
      end else if (acc) begin
        m.active = clampf(int'(duty_in));
      end
      m.running = 1;
      m.pos     = 0;
    end else if (m.running) begin
      m.pos++;
    end
    if (acc && !start) begin
      m.pfull = 1;
      m.pval  = clampf(int'(duty_in));
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(m10, 10);
    model_step(m5, 5);
    @(negedge clk);
    chk("pwm10",   int'(pwm10),   exp_pwm(m10, 10));
    chk("ps10",    int'(ps10),    int'(m10.ps));
    chk("cur10",   int'(cur10),   m10.active);
    chk("ready10", int'(ready10), int'(!m10.pfull));
    chk("clmp10",  int'(clmp10),  int'(m10.clmp));
    chk("pwm5",    int'(pwm5),    exp_pwm(m5, 5));
    chk("ps5",     int'(ps5),     int'(m5.ps));
    chk("cur5",    int'(cur5),    m5.active);
    chk("ready5",  int'(ready5),  int'(!m5.pfull));
    chk("clmp5",   int'(clmp5),   int'(m5.clmp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Holds a request until the TP=10 instance's slot is free at the edge, bounded
  task automatic send(input int d);
    bit taken;
    taken      = 0;
    duty_valid = 1'b1;
    duty_in    = 7'(d);
    for (int i = 0; i < 40 && !taken; i++) begin
      taken = !m10.pfull;
      cycle();
    end
    duty_valid = 1'b0;
    chk("send_accept", int'(taken), 1);
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    duty_valid = 1'b0;
    duty_in    = '0;
    model_reset(m10);
    model_reset(m5);
    @(negedge clk);
    run(2);
    rst = 1'b0;

    send(30);
    en = 1'b1;
    run(25);

    send(95);
    run(20);
    send(5);
    run(22);

    send(30);
    run(12);
    send(50);
    send(70);
    run(35);

    run(7);
    en = 1'b0;
    run(15);
    en = 1'b1;
    run(8);

    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(25);

    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      duty_valid = ($urandom_range(0, 3) == 0);
      duty_in    = 7'($urandom_range(0, 127));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
